r2sdf_fft: RTL and testbench
============================

# r2sdf_fft

Parametrised streaming radix-2 single-path delay-feedback (R2SDF) FFT core: accepts one complex sample per accepted cycle and produces one complex decimation-in-frequency (DIF) result per accepted cycle, in bit-reversed bin order. It replaces the fixed 8-point, two-phase-clock butterfly datapath with a single-clock design that is generic in point count and sample width. It also adds a valid handshake, bin tagging and frame markers. It sits between the sample front-end and the spectrum post-processing logic.

## Interface
- W, 8: input sample width per component (signed two's complement).
- LOG2N, 3: log2 of the FFT size N; legal range 1..6.
- TW, 10: twiddle width (signed); 1.0 is encoded as 2^(TW-2).
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  sample accept strobe; the pipeline advances only when this is high.
- in_re, in_im  in  W  complex input sample.
- out_valid  out  1  the output sample is meaningful.
- out_re, out_im  out  W+LOG2N  complex result, full growth, no scaling.
- out_bin  out  LOG2N  natural bin index of the current output.
- out_sof  out  1  high with the first output (bin 0) of each frame.

## Operation
- Stages s = 0..LOG2N-1. Stage s has a delay FIFO of depth D = N/2^(s+1), a butterfly, and a twiddle multiplier. Each stage ends with one output register.
- Each stage keeps a counter c_s of width LOG2N-s. It increments per accepted sample and wraps to 0. Phase = MSB of c_s; k = low bits of c_s.
- Phase 0: the incoming sample enters the FIFO. The FIFO head leaves as the stage output after multiplication by W_N^(k·2^s), where W_N = e^(-j2π/N).
- Phase 1 (butterfly): the output is head + input. head − input is written to the FIFO.
- Last stage (D=1): the twiddle is 1. No multiplier is instantiated.
- Width: stage s output width is W+s+1 per component. The sum and difference are computed at full width, with no overflow possible.
- Twiddle ROM: coefficient = round(cos or −sin(2πm/N) · 2^(TW−2)), computed at elaboration time.
- Product rounding: add 2^(TW−3), then arithmetic right shift by TW−2. The result is truncated to the stage width.
- The input frame counter starts at 0 after reset. Samples 0..N−1 form frame 0, and so on.
- Output order is bit-reversed. out_bin = bit-reverse of the output counter.
- out_sof = out_valid and output counter == 0.
- Primed flag: set once L = N−1+LOG2N samples have been accepted since reset.
- out_valid = in_valid and primed.
- No backpressure exists. Frames are flushed by feeding the next frame, or zeros.

## Timing
- Reset (asynchronous assert; deassert synchronous to clk): every FIFO entry, pipeline register, counter and the primed flag are cleared. out_valid, out_sof, out_re, out_im and out_bin all read 0.
- Latency is L = N−1+LOG2N accepted samples; for N=8, L = 10. Bin 0 of frame f appears coincident with the acceptance of input sample f·N+L.
- in_valid low for any number of cycles freezes all state. Outputs hold their last values, and out_valid = 0. Results are identical to gap-free input.
- Reset mid-frame discards the partial frame and all in-flight results. The first sample accepted after reset is sample 0 of frame 0.
- Counter wrap at N−1 → 0 is seamless. Back-to-back frames need no idle cycle.
- Extreme input −2^(W−1) on every sample must not overflow. For example, W=8, N=8 gives out_re = −1024 at bin 0.

## Test plan
- Impulse, N=8: frame (1,0,0,0,0,0,0,0), then zeros → 8 outputs with re=1, im=0. out_bin sequence is 0,4,2,6,1,5,3,7, and out_sof is high on the first output only.
- DC, N=8: all samples 5+0j → bin 0 = 40+0j, all other bins 0+0j, exact.
- Ramp 0..7 real, N=8 → bin0 = 28, bin4 = −4, bin2 = −4+4j, bin6 = −4−4j, all exact. Odd bins: re=−4±1 and im ≈ ±9.66/±1.66, within ±1 LSB.
- Alternating +1/−1, N=8 → bin 4 = 8+0j, all other bins 0. Repeat with in_valid toggled randomly → identical values and order.
- Back-to-back frames: ramp, then reversed ramp 7..0, then zeros → the second frame gives bin0 = 28 and bin4 = +4. out_sof pulses exactly once per frame, 8 samples apart.
- Assert reset at sample 5 of a frame, then send a fresh impulse frame → all outputs are 0 during reset. The impulse response appears L=10 accepted samples later, with no residue from the aborted frame.

Source files
------------

// File: rtl/r2sdf_fft.sv
// r2sdf_fft -- streaming radix-2 single-path delay-feedback FFT (DIF).
//
// One complex sample in, one complex result out per accepted cycle; results
// leave in bit-reversed bin order with full word growth (no scaling).
//
// Parameters
//   W      input component width (signed)
//   LOG2N  log2 of the transform size N (1..6)
//   TW     twiddle width (signed), 1.0 == 2^(TW-2)
// Ports
//   clk                 rising-edge clock
//   reset               asynchronous active-high reset
//   in_valid            sample accept strobe; all state advances only on it
//   in_re, in_im        input sample (W bits each)
//   out_valid           output meaningful (in_valid once the pipe is primed)
//   out_re, out_im      result (W+LOG2N bits each)
//   out_bin             natural bin index of the current result
//   out_sof             first result (bin 0) of a frame
module r2sdf_fft #(
    parameter int W     = 8,
    parameter int LOG2N = 3,
    parameter int TW    = 10
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    input  logic [W-1:0]         in_re,
    input  logic [W-1:0]         in_im,
    output logic                 out_valid,
    output logic [W+LOG2N-1:0]   out_re,
    output logic [W+LOG2N-1:0]   out_im,
    output logic [LOG2N-1:0]     out_bin,
    output logic                 out_sof
);
    localparam int N    = 1 << LOG2N;
    localparam int NH   = N / 2;
    localparam int WMAX = W + LOG2N;
    localparam int L    = N - 1 + LOG2N;
    localparam int PCW  = $clog2(L);
    localparam longint ONE = 64'sd1 <<< 28;

    // cos / -sin of 2*pi*m/N scaled by 2^(TW-2), rounded half away from zero.
    // Integer Taylor series in Q28 after folding the angle into [0, pi/2].
    function automatic int twiddle(input int m, input bit want_sin);
        longint pi_q, x, x2, t, acc, mag, r;
        bit     flip;
        pi_q = 64'sd843314857;
        x    = (pi_q * longint'(2 * m)) / longint'(N);
        flip = 1'b0;
        if (x > pi_q / 2) begin
            x    = pi_q - x;
            flip = !want_sin;
        end
        x2  = (x * x) >>> 28;
        t   = want_sin ? x : ONE;
        acc = t;
        for (int i = 1; i < 12; i++) begin
            if (want_sin) t = -(((t * x2) >>> 28) / longint'((2 * i) * (2 * i + 1)));
            else          t = -(((t * x2) >>> 28) / longint'((2 * i - 1) * (2 * i)));
            acc = acc + t;
        end
        if (flip)     acc = -acc;
        if (want_sin) acc = -acc;
        mag = (acc < 0) ? -acc : acc;
        r   = ((mag <<< (TW - 2)) + (ONE >>> 1)) >>> 28;
        return int'((acc < 0) ? -r : r);
    endfunction

    logic signed [TW-1:0] rom_c  [NH];
    logic signed [TW-1:0] rom_ns [NH];
    for (genvar m = 0; m < NH; m++) begin : g_rom
        assign rom_c[m]  = TW'(twiddle(m, 1'b0));
        assign rom_ns[m] = TW'(twiddle(m, 1'b1));
    end

    // Inter-stage data, sign-extended to the widest stage width.
    logic signed [WMAX-1:0] st_re [LOG2N+1];
    logic signed [WMAX-1:0] st_im [LOG2N+1];
    assign st_re[0] = WMAX'($signed(in_re));
    assign st_im[0] = WMAX'($signed(in_im));

    for (genvar s = 0; s < LOG2N; s++) begin : g_stage
        localparam int WO  = W + s + 1;
        localparam int D   = N >> (s + 1);
        localparam int CW  = LOG2N - s;
        // Samples reach stage s OFF accepted cycles after the input; the
        // counter starts at -OFF so its phase lines up with stage-local data.
        localparam int OFF = N - (N >> s) + s;
        localparam logic [CW-1:0] CRST = CW'((1 << CW) - (OFF % (1 << CW)));

        logic [CW-1:0]        c_q;
        logic signed [WO-1:0] fre_q [D];
        logic signed [WO-1:0] fim_q [D];
        logic signed [WO-1:0] ore_q, oim_q, ore_d, oim_d;
        logic signed [WO-1:0] a_re, a_im, h_re, h_im, t_re, t_im, wre, wim;

        assign a_re = WO'(st_re[s]);
        assign a_im = WO'(st_im[s]);
        assign h_re = fre_q[D-1];
        assign h_im = fim_q[D-1];

        if (s < LOG2N - 1) begin : g_tw
            localparam int PW = WO + TW + 1;
            localparam logic signed [PW-1:0] RND = PW'(2 ** (TW - 3));
            logic [LOG2N-2:0]     m;
            logic signed [TW-1:0] wc, ws;
            logic signed [PW-1:0] p_re, p_im;
            assign m    = (LOG2N - 1)'(c_q[CW-2:0]) << s;
            assign wc   = rom_c[m];
            assign ws   = rom_ns[m];
            assign p_re = PW'(h_re) * PW'(wc) - PW'(h_im) * PW'(ws);
            assign p_im = PW'(h_re) * PW'(ws) + PW'(h_im) * PW'(wc);
            assign t_re = WO'((p_re + RND) >>> (TW - 2));
            assign t_im = WO'((p_im + RND) >>> (TW - 2));
        end else begin : g_notw
            assign t_re = h_re;
            assign t_im = h_im;
        end

        // Phase 0: fill FIFO, emit twiddled difference from previous half.
        // Phase 1: emit sum, park the difference in the FIFO.
        always_comb begin
            if (c_q[CW-1]) begin
                ore_d = h_re + a_re;
                oim_d = h_im + a_im;
                wre   = h_re - a_re;
                wim   = h_im - a_im;
            end else begin
                ore_d = t_re;
                oim_d = t_im;
                wre   = a_re;
                wim   = a_im;
            end
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                c_q   <= CRST;
                ore_q <= '0;
                oim_q <= '0;
                for (int i = 0; i < D; i++) begin
                    fre_q[i] <= '0;
                    fim_q[i] <= '0;
                end
            end else if (in_valid) begin
                c_q      <= c_q + CW'(1);
                ore_q    <= ore_d;
                oim_q    <= oim_d;
                fre_q[0] <= wre;
                fim_q[0] <= wim;
                for (int i = 1; i < D; i++) begin
                    fre_q[i] <= fre_q[i-1];
                    fim_q[i] <= fim_q[i-1];
                end
            end
        end

        assign st_re[s+1] = WMAX'(ore_q);
        assign st_im[s+1] = WMAX'(oim_q);
    end

    // Priming and output bin tracking.
    logic [PCW-1:0]   pcnt_q, pcnt_d;
    logic             primed_q, primed_d;
    logic [LOG2N-1:0] ocnt_q, ocnt_d;

    assign primed_d  = primed_q | (in_valid & (pcnt_q == PCW'(L - 1)));
    assign pcnt_d    = (in_valid && !primed_q) ? pcnt_q + PCW'(1) : pcnt_q;
    assign out_valid = in_valid & primed_q;
    assign ocnt_d    = out_valid ? ocnt_q + LOG2N'(1) : ocnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pcnt_q   <= '0;
            primed_q <= 1'b0;
            ocnt_q   <= '0;
        end else begin
            pcnt_q   <= pcnt_d;
            primed_q <= primed_d;
            ocnt_q   <= ocnt_d;
        end
    end

    always_comb begin
        out_bin = '0;
        for (int i = 0; i < LOG2N; i++) out_bin[i] = ocnt_q[LOG2N-1-i];
    end

    assign out_sof = out_valid & (ocnt_q == '0);
    assign out_re  = st_re[LOG2N];
    assign out_im  = st_im[LOG2N];
endmodule

// File: tb/tb_r2sdf_fft.sv
// Directed bench for r2sdf_fft (W=8, N=8, TW=10): a table of streamed frames
// with hand-computed spectra, replayed gap-free and with random idle gaps,
// plus reset checks and a mid-frame reset sequence.
module tb_r2sdf_fft;
    localparam int W = 8, LOG2N = 3, TW = 10, N = 8, L = 10, NV = 64;

    logic        clk, reset, in_valid;
    logic [7:0]  in_re, in_im;
    logic        out_valid, out_sof;
    logic [10:0] out_re, out_im;
    logic [2:0]  out_bin;

    r2sdf_fft #(.W(W), .LOG2N(LOG2N), .TW(TW)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid),
        .in_re(in_re), .in_im(in_im),
        .out_valid(out_valid), .out_re(out_re), .out_im(out_im),
        .out_bin(out_bin), .out_sof(out_sof)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int re_i, im_i;
        bit chk;
        int exp_re, exp_im, tol, exp_bin;
        bit exp_sof;
    } vec_t;

    vec_t tbl [NV];
    int   sre [8][8], sim [8][8], stol [8][8];
    int   n_chk = 0, n_fail = 0;

    function automatic int br3(input int j);
        return ((j & 1) << 2) | (j & 2) | ((j >> 2) & 1);
    endfunction

    task automatic chk_int(input string name, input int act, input int exp, input int tol);
        n_chk++;
        if (act < exp - tol || act > exp + tol) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d +/- %0d", name, act, exp, tol);
        end
    endtask

    task automatic check_out(input string tag, input int i, input bit ev, input bit dchk,
                             input int er, input int ei, input int tol, input int eb, input bit es);
        chk_int($sformatf("%s[%0d] valid", tag, i), int'(out_valid), int'(ev), 0);
        chk_int($sformatf("%s[%0d] sof", tag, i), int'(out_sof), int'(es), 0);
        if (dchk) begin
            chk_int($sformatf("%s[%0d] bin", tag, i), int'(out_bin), eb, 0);
            chk_int($sformatf("%s[%0d] re", tag, i), int'($signed(out_re)), er, tol);
            chk_int($sformatf("%s[%0d] im", tag, i), int'($signed(out_im)), ei, tol);
        end
    endtask

    task automatic check_zero(input string tag, input int i);
        check_out(tag, i, 1'b0, 1'b1, 0, 0, 0, 0, 1'b0);
    endtask

    task automatic run_table(input string tag, input bit gaps);
        for (int i = 0; i < NV; i++) begin
            if (gaps) begin
                for (int g = 0; g < 4 && $urandom_range(0, 2) == 0; g++) begin
                    @(posedge clk); #1;
                    in_valid = 1'b0;
                    #1;
                    // While stalled the output register holds what sample i will show.
                    check_out({tag, "_gap"}, i, 1'b0, tbl[i].chk, tbl[i].exp_re,
                              tbl[i].exp_im, tbl[i].tol, tbl[i].exp_bin, 1'b0);
                end
            end
            @(posedge clk); #1;
            in_valid = 1'b1;
            in_re    = 8'(tbl[i].re_i);
            in_im    = 8'(tbl[i].im_i);
            #1;
            check_out(tag, i, tbl[i].chk, tbl[i].chk, tbl[i].exp_re, tbl[i].exp_im,
                      tbl[i].tol, tbl[i].exp_bin, tbl[i].exp_sof);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic pulse_reset();
        in_valid = 1'b0;
        reset    = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_re = '0; in_im = '0;

        // Expected spectra per frame, natural bin order.
        for (int f = 0; f < 8; f++)
            for (int k = 0; k < 8; k++) begin
                sre[f][k] = 0; sim[f][k] = 0; stol[f][k] = 0;
            end
        for (int k = 0; k < 8; k++) sre[0][k] = 1;            // impulse
        sre[1][0] = 40;                                       // DC 5
        sre[2] = '{28, -4, -4, -4, -4, -4, -4, -4};           // ramp 0..7
        sim[2] = '{0, 10, 4, 2, 0, -2, -4, -10};
        sre[3] = '{28, 4, 4, 4, 4, 4, 4, 4};                  // ramp 7..0
        sim[3] = '{0, -10, -4, -2, 0, 2, 4, 10};
        for (int k = 1; k < 8; k += 2) begin stol[2][k] = 1; stol[3][k] = 1; end
        sre[4][4] = 8;                                        // +1/-1
        sre[5][0] = -1024; sim[5][0] = -1024;                 // all -128

        for (int i = 0; i < NV; i++) begin
            int f, n, j;
            f = i / N; n = i % N;
            case (f)
                0:       begin tbl[i].re_i = (n == 0) ? 1 : 0; tbl[i].im_i = 0; end
                1:       begin tbl[i].re_i = 5;                tbl[i].im_i = 0; end
                2:       begin tbl[i].re_i = n;                tbl[i].im_i = 0; end
                3:       begin tbl[i].re_i = 7 - n;            tbl[i].im_i = 0; end
                4:       begin tbl[i].re_i = (n % 2) ? -1 : 1; tbl[i].im_i = 0; end
                5:       begin tbl[i].re_i = -128;             tbl[i].im_i = -128; end
                default: begin tbl[i].re_i = 0;                tbl[i].im_i = 0; end
            endcase
            tbl[i].chk = (i >= L);
            if (i >= L) begin
                f = (i - L) / N; j = (i - L) % N;
                tbl[i].exp_bin = br3(j);
                tbl[i].exp_sof = (j == 0);
                tbl[i].exp_re  = sre[f][br3(j)];
                tbl[i].exp_im  = sim[f][br3(j)];
                tbl[i].tol     = stol[f][br3(j)];
            end else begin
                tbl[i].exp_bin = 0; tbl[i].exp_sof = 1'b0;
                tbl[i].exp_re = 0; tbl[i].exp_im = 0; tbl[i].tol = 0;
            end
        end

        // Reset state.
        repeat (2) @(posedge clk);
        #1 check_zero("reset", 0);
        @(negedge clk) reset = 1'b0;

        run_table("stream", 1'b0);
        pulse_reset();
        #1 check_zero("reset2", 0);
        run_table("gapped", 1'b1);

        // Abort a ramp frame at sample 5, then a fresh impulse frame.
        for (int n = 0; n < 5; n++) begin
            @(posedge clk); #1;
            in_valid = 1'b1; in_re = 8'(n); in_im = '0;
        end
        @(posedge clk); #1;
        in_re = 8'd5; reset = 1'b1;
        #1 check_zero("midrst", 0);
        for (int c = 1; c < 3; c++) begin
            @(posedge clk); #1 check_zero("midrst", c);
        end
        in_valid = 1'b0;
        @(negedge clk) reset = 1'b0;
        for (int i = 0; i < 24; i++) begin
            @(posedge clk); #1;
            in_valid = 1'b1; in_re = (i == 0) ? 8'd1 : 8'd0; in_im = '0;
            #1;
            if (i < L) check_out("after_rst", i, 1'b0, 1'b0, 0, 0, 0, 0, 1'b0);
            else check_out("after_rst", i, 1'b1, 1'b1, (i < L + N) ? 1 : 0, 0, 0,
                           br3((i - L) % N), ((i - L) % N) == 0);
        end
        @(posedge clk); #1 in_valid = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
